ysyx_22050368_exmem_buf: RTL

EX→MEM pipeline buffer for the ysyx_22050368 core. It sits directly downstream of the execute-stage ALU and captures each ALU result with its flags, destination register and PC. It presents them to the memory stage over a valid/ready handshake. A two-entry skid structure sustains one transfer per cycle without a combinational ready path from the memory stage back to execute. The head entry also drives a forwarding port for the upstream hazard unit.

---
 rtl/ysyx_22050368_pkg.sv | 30 +++
 rtl/ysyx_22050368_exbuf_entry.sv | 28 ++
 rtl/ysyx_22050368_exmem_buf.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050368_pkg.sv
// Shared definitions for the ysyx_22050368 pipeline buffers: default widths,
// buffer FSM encoding and the packed EX->MEM entry layout.
package ysyx_22050368_pkg;

  localparam int DEF_XLEN   = 64;
  localparam int DEF_RIDX_W = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Field order matches the packing used by the buffers: result is the MSBs.
  typedef struct packed {
    logic [DEF_XLEN-1:0]   result;
    logic                  zero;
    logic                  overflow;
    logic [DEF_RIDX_W-1:0] rd;
    logic                  wen;
    logic [DEF_XLEN-1:0]   pc;
  } exmem_entry_t;

  localparam int EXMEM_ENTRY_W = $bits(exmem_entry_t);

  function automatic int exmem_entry_width(input int xlen, input int ridx_w);
    return 2 * xlen + ridx_w + 3;
  endfunction

endpackage

// File: rtl/ysyx_22050368_exbuf_entry.sv
// One load-enabled pipeline entry (payload + valid). Reset zeroes everything;
// clr drops only the valid bit so the payload keeps its last value.
module ysyx_22050368_exbuf_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         d_valid,
  input  logic [W-1:0] d,
  output logic         q_valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/ysyx_22050368_exmem_buf.sv
// EX->MEM two-entry skid buffer with forwarding port and optional perf
// counters (enabled by defining YSYX_22050368_EXBUF_PERF_EN).
module ysyx_22050368_exmem_buf
  import ysyx_22050368_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int RIDX_W = DEF_RIDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_result,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_zero,
  output logic              out_overflow,
  output logic [RIDX_W-1:0] out_rd,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_pc,
  output logic              fwd_valid,
  output logic [RIDX_W-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_ovf_cnt
);

  localparam int W = 2 * XLEN + RIDX_W + 3;

  buf_state_e state_reg, state_next;
  logic       rst_done_reg;

  logic         head_valid, skid_valid;
  logic [W-1:0] head_q, skid_q, in_packed, head_d;
  logic         head_load, head_clr, head_from_skid, head_d_valid;
  logic         skid_load, skid_clr;
  logic         accept, retire;

  assign in_packed = {in_result, in_zero, in_overflow, in_rd, in_wen, in_pc};

  // rst_done_reg keeps in_ready low throughout reset, using registered state only.
  assign in_ready  = rst_done_reg && (state_reg != ST_TWO);
  assign out_valid = head_valid;
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    head_load      = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
      head_clr   = 1'b1;
      skid_clr   = 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            head_load  = 1'b1;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && retire) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            state_next = ST_TWO;
          end else if (retire) begin
            head_clr   = 1'b1;
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (retire) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_next     = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  assign head_d       = head_from_skid ? skid_q : in_packed;
  assign head_d_valid = head_from_skid ? skid_valid : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      rst_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rst_done_reg <= 1'b1;
    end
  end

  ysyx_22050368_exbuf_entry #(.W(W)) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (head_clr),
    .load    (head_load),
    .d_valid (head_d_valid),
    .d       (head_d),
    .q_valid (head_valid),
    .q       (head_q)
  );

  ysyx_22050368_exbuf_entry #(.W(W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (skid_clr),
    .load    (skid_load),
    .d_valid (1'b1),
    .d       (in_packed),
    .q_valid (skid_valid),
    .q       (skid_q)
  );

  assign {out_result, out_zero, out_overflow, out_rd, out_wen, out_pc} = head_q;

  assign fwd_valid = head_valid && out_wen && (out_rd != '0);
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;

`ifdef YSYX_22050368_EXBUF_PERF_EN
  logic [31:0] stall_cnt_reg, ovf_cnt_reg;

  // Only entries actually captured count as overflow; flush-cycle inputs are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      ovf_cnt_reg   <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (accept && !flush && in_overflow && (ovf_cnt_reg != 32'hFFFF_FFFF))
        ovf_cnt_reg <= ovf_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_ovf_cnt   = ovf_cnt_reg;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_ovf_cnt   = 32'h0;
`endif

endmodule
